lane_fifo_valid: RTL
====================

Name: lane_fifo_valid

Overview:
- Per-lane synchronous FIFO that buffers 4-bit lane data upstream of the 2:1 lane mux stage.
- Presents registered data_out plus valid_out in the form the mux consumes: data is zero whenever valid is low.
- Generates the full, empty and threshold flags used by the flow-control logic.
- Two instances, one per lane, drive the mux data inputs in0/in1 and valid inputs valid_bit0/valid_bit1.

Parameters:
- DATA_W, 4, width of data_in/data_out.
- DEPTH, 8, number of entries; power of two, at least 4.
- AF_THR, 6, almost_full asserts when count >= AF_THR; range 1..DEPTH.
- AE_THR, 2, almost_empty asserts when count <= AE_THR; range 0..DEPTH-1.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- push, input, 1, write request.
- data_in, input, DATA_W, write data; sampled when push is accepted.
- pop, input, 1, read request.
- data_out, output, DATA_W, registered read data; 0 when valid_out=0.
- valid_out, output, 1, data_out holds an entry popped on the previous cycle.
- full, output, 1, count == DEPTH.
- empty, output, 1, count == 0.
- almost_full, output, 1, count >= AF_THR.
- almost_empty, output, 1, count <= AE_THR.
- err_overflow, output, 1, sticky; set by push while full without a same-cycle accepted pop.
- err_underflow, output, 1, sticky; set by pop while empty.

Behaviour:
- Reset, sampled at the rising edge while reset=1:
  - wr_ptr, rd_ptr and count reset to 0.
  - data_out=0, valid_out=0, err_overflow=0, err_underflow=0.
  - Flags after reset: empty=1, full=0, almost_empty=1; almost_full=0 (AF_THR>=1).
  - Memory contents are not reset and are never observable, because data_out is forced to 0 when valid_out=0.
- Accept rules, evaluated on state before the edge:
  - pop_ok = pop & ~empty.
  - push_ok = push & (~full | pop_ok).
  - No fall-through: on an empty FIFO a simultaneous push and pop accepts the push only. The pop is an underflow.
  - Full FIFO with push and pop in the same cycle: both accepted, count unchanged.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH naturally. count is $clog2(DEPTH+1) bits and changes by +1, -1 or 0 per cycle.
- Read latency is 1 cycle:
  - On a pop_ok cycle: data_out <= mem[rd_ptr] and valid_out <= 1 at the next edge.
  - Otherwise: valid_out <= 0 and data_out <= 0.
  - valid_out is never high for two cycles from a single pop.
- Write: on push_ok, mem[wr_ptr] <= data_in. A same-cycle read of the same address returns the old contents; this occurs only when full.
- Flags are combinational decodes of the registered count, so they reflect the edge just taken, with no extra latency.
- Error flags:
  - err_overflow <= 1 when push & ~push_ok.
  - err_underflow <= 1 when pop & ~pop_ok.
  - Both hold until reset. A rejected push is dropped and leaves the contents unchanged.
- Reset mid-operation: any in-flight entries are discarded. valid_out drops the cycle after reset is sampled, even if a pop coincided with reset; reset has priority over all operations.
- Parameter legality (DEPTH power of two, AE_THR < AF_THR) is checked by an elaboration-time assertion.

Decomposition:
- Shared package lane_pkg:
  - LANE_W = 4.
  - FIFO_DEPTH = 8.
  - Default AF/AE thresholds.
  - Typedef lane_data_t, reused by the mux and demux stages.
- One sub-module: fifo_mem_dp, a DEPTH x DATA_W register array with a synchronous write port and an asynchronous read port. Pointers, count, flags and the output register stay in lane_fifo_valid.

Test Plan:
1. Reset, then push 0xA, 0x3, 0xF on consecutive cycles, then pop three times back to back -> valid_out high for three consecutive cycles one cycle after each pop, data_out 0xA, 0x3, 0xF; data_out=0 on the following cycle; empty=1 at the end.
2. Push 8 entries 0x0..0x7 -> full=1 after the 8th; almost_full=1 once count reaches 6. A 9th push with 0x9 -> err_overflow=1, count stays 8. Draining yields 0x0..0x7 only.
3. Full FIFO, push 0xC with pop on the same cycle -> data_out=0x0 with valid_out=1 next cycle, count stays 8, no error. The last entry drained is 0xC.
4. Empty FIFO, push 0x5 with pop on the same cycle -> valid_out=0 next cycle, err_underflow=1, count=1. A following pop returns 0x5.
5. Wrap: 20 push/pop cycles at one entry in flight, values 0x0..0x3 repeating -> output sequence matches input with 1-cycle latency; pointers wrap cleanly; almost_empty stays 1.
6. Fill 5 entries, assert reset together with a pop -> next cycle valid_out=0, data_out=0, empty=1, both error flags 0. A subsequent pop raises err_underflow.

Source files
------------

// File: rtl/lane_fifo_valid_pkg.sv
// lane_pkg: shared lane widths, FIFO defaults and the lane data type
package lane_pkg;
  localparam int LANE_W = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int AF_THR_DEF = 6;
  localparam int AE_THR_DEF = 2;
  typedef logic [LANE_W-1:0] lane_data_t;
  function automatic bit is_pow2(int v);
    return v > 0 && (v & (v - 1)) == 0;
  endfunction
endpackage

// File: rtl/lane_fifo_valid_if.sv
// lane_fifo_valid_if: push/pop handshake, read data and status flags of one lane FIFO
interface lane_fifo_valid_if #(parameter int DATA_W = lane_pkg::LANE_W);
  logic push;
  logic pop;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic valid_out;
  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  logic err_overflow;
  logic err_underflow;
  modport master (
    output push, pop, data_in,
    input data_out, valid_out, full, empty, almost_full, almost_empty, err_overflow, err_underflow
  );
  modport slave (
    input push, pop, data_in,
    output data_out, valid_out, full, empty, almost_full, almost_empty, err_overflow, err_underflow
  );
endinterface

// File: rtl/lane_fifo_valid_fifo_mem_dp.sv
// fifo_mem_dp: DEPTH x DATA_W register array, synchronous write, asynchronous read
module fifo_mem_dp #(
  parameter int DATA_W = 4,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/lane_fifo_valid.sv
// lane_fifo_valid: per-lane FIFO with registered, zero-when-invalid output and flow-control flags
module lane_fifo_valid
  import lane_pkg::*;
#(
  parameter int DATA_W = LANE_W,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AF_THR = AF_THR_DEF,
  parameter int AE_THR = AE_THR_DEF
) (
  input logic clk,
  input logic reset,
  lane_fifo_valid_if.slave io
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  if (!(is_pow2(DEPTH) && DEPTH >= 4 && AE_THR < AF_THR && AF_THR >= 1 && AF_THR <= DEPTH && AE_THR >= 0)) begin : g_bad_params
    $error("lane_fifo_valid: illegal DEPTH/AF_THR/AE_THR");
  end
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d, rd_data;
  logic valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d;
  logic pop_ok, push_ok;
  fifo_mem_dp #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (io.data_in),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );
  assign io.empty = count_q == '0;
  assign io.full = count_q == CW'(DEPTH);
  assign io.almost_full = count_q >= CW'(AF_THR);
  assign io.almost_empty = count_q <= CW'(AE_THR);
  assign io.data_out = data_out_q;
  assign io.valid_out = valid_q;
  assign io.err_overflow = ovf_q;
  assign io.err_underflow = unf_q;
  // a pop on an empty FIFO never falls through to a same-cycle push
  assign pop_ok = io.pop & ~io.empty;
  assign push_ok = io.push & (~io.full | pop_ok);
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    valid_d = pop_ok;
    data_out_d = pop_ok ? rd_data : '0;
    ovf_d = ovf_q | (io.push & ~push_ok);
    unf_d = unf_q | (io.pop & ~pop_ok);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      data_out_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      data_out_q <= data_out_d;
      valid_q <= valid_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
endmodule
